// File: rtl/morse_pkg.sv
// Shared definitions for the Morse decoder slice.
// Holds the FSM state encoding, the symbol encodings, the maximum code
// length and the letter index constants (A=0 .. Z=25), which match the
// seven-segment stage's letter encoding.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int unsigned MAX_CODE_LEN = 4;

    localparam logic [4:0] LTR_A = 5'd0;
    localparam logic [4:0] LTR_B = 5'd1;
    localparam logic [4:0] LTR_C = 5'd2;
    localparam logic [4:0] LTR_D = 5'd3;
    localparam logic [4:0] LTR_E = 5'd4;
    localparam logic [4:0] LTR_F = 5'd5;
    localparam logic [4:0] LTR_G = 5'd6;
    localparam logic [4:0] LTR_H = 5'd7;
    localparam logic [4:0] LTR_I = 5'd8;
    localparam logic [4:0] LTR_J = 5'd9;
    localparam logic [4:0] LTR_K = 5'd10;
    localparam logic [4:0] LTR_L = 5'd11;
    localparam logic [4:0] LTR_M = 5'd12;
    localparam logic [4:0] LTR_N = 5'd13;
    localparam logic [4:0] LTR_O = 5'd14;
    localparam logic [4:0] LTR_P = 5'd15;
    localparam logic [4:0] LTR_Q = 5'd16;
    localparam logic [4:0] LTR_R = 5'd17;
    localparam logic [4:0] LTR_S = 5'd18;
    localparam logic [4:0] LTR_T = 5'd19;
    localparam logic [4:0] LTR_U = 5'd20;
    localparam logic [4:0] LTR_V = 5'd21;
    localparam logic [4:0] LTR_W = 5'd22;
    localparam logic [4:0] LTR_X = 5'd23;
    localparam logic [4:0] LTR_Y = 5'd24;
    localparam logic [4:0] LTR_Z = 5'd25;

endpackage

// File: rtl/morse_code_lut.sv
// Combinational Morse code-to-letter table.
// Ports:
//   code   - symbols right-aligned, first symbol in the MSB of the used field
//   len    - number of symbols in code (1-4)
//   letter - letter index A=0 .. Z=25 (LTR_A when no hit)
//   hit    - code/len form a valid letter
module morse_code_lut
    import morse_pkg::*;
(
    input  logic [3:0] code,
    input  logic [2:0] len,
    output logic [4:0] letter,
    output logic       hit
);

    always_comb begin
        letter = LTR_A;
        hit    = 1'b1;
        case (len)
            3'd1: letter = code[0] ? LTR_T : LTR_E;
            3'd2: begin
                case (code[1:0])
                    2'b00: letter = LTR_I;
                    2'b01: letter = LTR_A;
                    2'b10: letter = LTR_N;
                    2'b11: letter = LTR_M;
                endcase
            end
            3'd3: begin
                case (code[2:0])
                    3'b000: letter = LTR_S;
                    3'b001: letter = LTR_U;
                    3'b010: letter = LTR_R;
                    3'b011: letter = LTR_W;
                    3'b100: letter = LTR_D;
                    3'b101: letter = LTR_K;
                    3'b110: letter = LTR_G;
                    3'b111: letter = LTR_O;
                endcase
            end
            3'd4: begin
                case (code)
                    4'b0000: letter = LTR_H;
                    4'b0001: letter = LTR_V;
                    4'b0010: letter = LTR_F;
                    4'b0100: letter = LTR_L;
                    4'b0110: letter = LTR_P;
                    4'b0111: letter = LTR_J;
                    4'b1000: letter = LTR_B;
                    4'b1001: letter = LTR_X;
                    4'b1010: letter = LTR_C;
                    4'b1011: letter = LTR_Y;
                    4'b1100: letter = LTR_Z;
                    4'b1101: letter = LTR_Q;
                    default: hit = 1'b0;   // ..--  .-.-  ---.  ----
                endcase
            end
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: times key presses into dots/dashes, collects up to four
// symbols per letter and decodes the letter after a long enough release.
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset
//   key_i    - debounced key level (1 = pressed)
//   letter_o - last decoded letter index (registered, held between pulses)
//   valid_o  - one-cycle pulse: new letter on letter_o
//   error_o  - one-cycle pulse: terminated sequence was not a letter
//   busy_o   - a letter is in progress (registered state not IDLE)
module morse_decoder
    import morse_pkg::*;
#(
    parameter int unsigned DOT_MAX_TICKS    = 3000,
    parameter int unsigned LETTER_GAP_TICKS = 9000,
    parameter int unsigned CNT_W            = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_i,
    output logic [4:0] letter_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       busy_o
);

    localparam logic [CNT_W-1:0] DOT_MAX  = CNT_W'(DOT_MAX_TICKS);
    // Counter holds released samples already taken, so the terminating
    // sample is the one seen while the count equals LETTER_GAP_TICKS-1.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LETTER_GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic [2:0]       len_q, len_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       letter_q, letter_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;

    logic [4:0]       lut_letter;
    logic             lut_hit;
    logic             sym;

    morse_code_lut u_lut (
        .code   (code_q),
        .len    (len_q),
        .letter (lut_letter),
        .hit    (lut_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            code_q   <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            letter_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        letter_d = letter_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        sym      = (cnt_q >= DOT_MAX) ? DASH : DOT;

        case (state_q)
            ST_IDLE: begin
                if (key_i) begin
                    state_d = ST_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS: begin
                if (key_i) begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_ONE;
                    // Length stays at the maximum once full, so this also
                    // drops every symbol after the overflowing one.
                    if (len_q == 3'(MAX_CODE_LEN)) begin
                        ovf_d = 1'b1;
                    end else begin
                        code_d = {code_q[2:0], sym};
                        len_d  = len_q + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (key_i) begin
                    state_d = ST_PRESS;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    code_d  = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    if (!ovf_q && lut_hit) begin
                        valid_d  = 1'b1;
                        letter_d = lut_letter;
                    end else begin
                        error_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign letter_o = letter_q;
    assign valid_o  = valid_q;
    assign error_o  = error_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: stimulus pushes the expected outcome of
// each letter into a queue, a monitor pops and compares on every pulse.
module tb_morse_decoder;

    localparam int DOT = 4;
    localparam int GAP = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic [4:0] letter_o;
    logic       valid_o;
    logic       error_o;
    logic       busy_o;

    always #5 clk = ~clk;

    morse_decoder #(
        .DOT_MAX_TICKS    (DOT),
        .LETTER_GAP_TICKS (GAP),
        .CNT_W            (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_i    (key),
        .letter_o (letter_o),
        .valid_o  (valid_o),
        .error_o  (error_o),
        .busy_o   (busy_o)
    );

    typedef struct {
        bit         is_err;
        logic [4:0] letter;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [4:0] model_letter = '0;

    string codes[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                         "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                         "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                         "-.--", "--.."};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: symbol string -> expected outcome using the Morse table.
    task automatic push_expect(input string s);
        exp_t e;
        e.is_err = 1'b1;
        e.letter = model_letter;
        if (s.len() <= 4) begin
            for (int i = 0; i < 26; i++) begin
                if (codes[i] == s) begin
                    e.is_err     = 1'b0;
                    e.letter     = 5'(i);
                    model_letter = 5'(i);
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic hold(input logic v, input int n);
        key = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic finish_letter(input string s);
        push_expect(s);
        hold(1'b0, GAP - 1);
        chk("no_early_termination", {31'd0, valid_o | error_o}, 32'd0);
        hold(1'b0, 1);
        chk("decode_latency", {31'd0, valid_o | error_o}, 32'd1);
    endtask

    task automatic play(input int p[$], input int g[$]);
        string s;
        s = "";
        for (int i = 0; i < p.size(); i++) begin
            hold(1'b1, p[i]);
            if (p[i] >= DOT) s = {s, "-"};
            else             s = {s, "."};
            if (i < p.size() - 1) hold(1'b0, g[i]);
        end
        finish_letter(s);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    initial begin : monitor
        logic prev;
        logic pulse;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            pulse = valid_o | error_o;
            if (pulse) begin
                chk("valid_error_exclusive", {31'd0, valid_o & error_o}, 32'd0);
                chk("no_back_to_back_pulse", {31'd0, prev}, 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got valid=%0d error=%0d expected none",
                             valid_o, error_o);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind_valid", {31'd0, valid_o}, {31'd0, !e.is_err});
                    chk("letter_value", {27'd0, letter_o}, {27'd0, e.letter});
                end
            end
            prev = pulse;
        end
    end

    initial begin : stim
        int p[$];
        int g[$];
        int n;
        rst = 1'b1;
        key = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_letter", {27'd0, letter_o}, 32'd0);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_error", {31'd0, error_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        hold(1'b0, 2);

        // Directed cases
        p = '{2};          g.delete();       play(p, g);   // E
        p = '{2, 6};       g = '{3};         play(p, g);   // A
        p = '{4};          g.delete();       play(p, g);   // T (boundary)
        p = '{3};          g.delete();       play(p, g);   // E (boundary)
        p = '{5, 4, 6, 7}; g = '{2, 2, 2};   play(p, g);   // ---- error
        p = '{1, 2, 3, 1, 2}; g = '{11, 11, 11, 11}; play(p, g); // overflow

        // Reset during the third symbol of -...
        hold(1'b1, 5);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 3);
        hold(1'b1, 2);
        rst = 1'b1;
        hold(1'b1, 2);
        chk("midletter_reset_busy", {31'd0, busy_o}, 32'd0);
        chk("midletter_reset_letter", {27'd0, letter_o}, 32'd0);
        model_letter = '0;
        rst = 1'b0;
        hold(1'b1, 1);
        chk("press_starts_after_reset", {31'd0, busy_o}, 32'd1);
        hold(1'b1, 2);
        finish_letter(".");

        // Random letters, including invalid and overflowing sequences
        repeat (40) begin
            p.delete();
            g.delete();
            if ($urandom_range(0, 3) != 0) begin
                string c;
                c = codes[$urandom_range(0, 25)];
                for (int i = 0; i < c.len(); i++)
                    p.push_back(c[i] == "-" ? int'($urandom_range(DOT, DOT + 5))
                                            : int'($urandom_range(1, DOT - 1)));
            end else begin
                n = int'($urandom_range(4, 6));
                for (int i = 0; i < n; i++)
                    p.push_back(int'($urandom_range(1, DOT + 3)));
            end
            for (int i = 1; i < p.size(); i++)
                g.push_back(int'($urandom_range(1, GAP - 1)));
            play(p, g);
            hold(1'b0, int'($urandom_range(0, 3)));
        end

        hold(1'b0, 4);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
